// File: rtl/alu_181_pkg.sv
// Shared types and select/mode codes for the nibble-serial 74181-style ALU.
package alu_181_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0] SEL_0 = 4'b0000;
   localparam logic [3:0] SEL_1 = 4'b0001;
   localparam logic [3:0] SEL_2 = 4'b0010;
   localparam logic [3:0] SEL_3 = 4'b0011;
   localparam logic [3:0] SEL_4 = 4'b0100;
   localparam logic [3:0] SEL_5 = 4'b0101;
   localparam logic [3:0] SEL_6 = 4'b0110;
   localparam logic [3:0] SEL_7 = 4'b0111;
   localparam logic [3:0] SEL_8 = 4'b1000;
   localparam logic [3:0] SEL_9 = 4'b1001;
   localparam logic [3:0] SEL_A = 4'b1010;
   localparam logic [3:0] SEL_B = 4'b1011;
   localparam logic [3:0] SEL_C = 4'b1100;
   localparam logic [3:0] SEL_D = 4'b1101;
   localparam logic [3:0] SEL_E = 4'b1110;
   localparam logic [3:0] SEL_F = 4'b1111;

   localparam logic MODE_ARITH = 1'b0;
   localparam logic MODE_LOGIC = 1'b1;

endpackage

// File: rtl/alu_181_slice.sv
// Combinational 4-bit 74181-style slice; X/Y are formed locally so ONES = 4'hF per slice.
module alu_181_slice
   import alu_181_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] s,
   input  logic       m,
   input  logic       cin,
   output logic [3:0] f,
   output logic       cout,
   output logic       c3
);

   logic [3:0] x;
   logic [3:0] y;
   logic [3:0] lf;
   logic [4:0] sum;
   logic [3:0] low;

   always_comb begin
      x = a;
      y = 4'h0;
      case (s)
         SEL_0: begin x = a;        y = 4'h0;     end
         SEL_1: begin x = a | b;    y = 4'h0;     end
         SEL_2: begin x = a | ~b;   y = 4'h0;     end
         SEL_3: begin x = 4'hF;     y = 4'h0;     end
         SEL_4: begin x = a;        y = a & ~b;   end
         SEL_5: begin x = a | b;    y = a & ~b;   end
         SEL_6: begin x = a;        y = ~b;       end
         SEL_7: begin x = a & ~b;   y = 4'hF;     end
         SEL_8: begin x = a;        y = a & b;    end
         SEL_9: begin x = a;        y = b;        end
         SEL_A: begin x = a | ~b;   y = a & b;    end
         SEL_B: begin x = a & b;    y = 4'hF;     end
         SEL_C: begin x = a;        y = a;        end
         SEL_D: begin x = a | b;    y = a;        end
         SEL_E: begin x = a | ~b;   y = a;        end
         default: begin x = a;      y = 4'hF;     end
      endcase
   end

   always_comb begin
      lf = 4'h0;
      case (s)
         SEL_0: lf = ~a;
         SEL_1: lf = ~(a | b);
         SEL_2: lf = ~a & b;
         SEL_3: lf = 4'h0;
         SEL_4: lf = ~(a & b);
         SEL_5: lf = ~b;
         SEL_6: lf = a ^ b;
         SEL_7: lf = a & ~b;
         SEL_8: lf = ~a | b;
         SEL_9: lf = ~(a ^ b);
         SEL_A: lf = b;
         SEL_B: lf = a & b;
         SEL_C: lf = 4'hF;
         SEL_D: lf = a | ~b;
         SEL_E: lf = a | b;
         default: lf = a;
      endcase
   end

   // The 3-bit partial sum exposes the carry into bit 3 for overflow detection on the top slice.
   always_comb begin
      sum  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
      low  = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, cin};
      f    = sum[3:0];
      cout = sum[4];
      c3   = low[3];
      if (m == MODE_LOGIC) begin
         f    = lf;
         cout = 1'b0;
         c3   = 1'b0;
      end
   end

endmodule

// File: rtl/alu_181_serial.sv
// Nibble-serial ALU: one 4-bit slice per clock, LSB first, with the carry held between slices.
module alu_181_serial
   import alu_181_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             cout,
   output logic             ovf,
   output logic             aeqb
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   state_t            state;
   state_t            next_state;
   logic [CW-1:0]     cnt;
   logic              carry;
   logic [WIDTH-1:0]  a_reg;
   logic [WIDTH-1:0]  b_reg;
   logic [3:0]        s_reg;
   logic              m_reg;
   logic [WIDTH-1:0]  f_next;
   logic [3:0]        slice_f;
   logic              slice_cout;
   logic              slice_c3;

   alu_181_slice u_slice (
      .a    (a_reg[{cnt, 2'b00} +: 4]),
      .b    (b_reg[{cnt, 2'b00} +: 4]),
      .s    (s_reg),
      .m    (m_reg),
      .cin  (carry),
      .f    (slice_f),
      .cout (slice_cout),
      .c3   (slice_c3)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid)    next_state = RUN;
         RUN:     if (cnt == LAST) next_state = DONE;
         DONE:    if (out_ready)   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_comb begin
      f_next = f;
      f_next[{cnt, 2'b00} +: 4] = slice_f;
   end

   // Flags are only committed on the last nibble so they stay stable through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         carry <= 1'b0;
         a_reg <= '0;
         b_reg <= '0;
         s_reg <= 4'h0;
         m_reg <= 1'b0;
         f     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         aeqb  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
                  s_reg <= s;
                  m_reg <= m;
                  cnt   <= '0;
                  carry <= cin;
               end
            end
            RUN: begin
               f     <= f_next;
               carry <= slice_cout;
               if (cnt == LAST) begin
                  cnt  <= '0;
                  cout <= slice_cout;
                  ovf  <= slice_c3 ^ slice_cout;
                  aeqb <= &f_next;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/alu_181_serial.md
# alu_181_serial

Parametrised, nibble-serial successor to our 4-bit 74181-style arithmetic unit. It accepts WIDTH-bit operands, a 4-bit function select, a mode bit and a carry-in through a valid/ready handshake. The operation runs LSB-first, one 4-bit slice per clock, with the carry held in a register between slices. Result, carry-out, signed overflow and A=B are returned through a valid/ready output handshake. It sits between the operand registers and the result bus in the ALU datapath.

## Interface
- WIDTH, 8: operand/result width. Must be a multiple of 4, range 4..32. NIBBLES = WIDTH/4.
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  high only in IDLE
- a, b  in  WIDTH  operands, sampled on accept
- s  in  4  function select
- m  in  1  mode: 0 = arithmetic, 1 = logic
- cin  in  1  active-high carry-in (1 adds one); ignored when m=1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- f  out  WIDTH  result
- cout  out  1  carry out of bit WIDTH-1; 0 when m=1
- ovf  out  1  signed overflow: carry into MSB XOR cout; 0 when m=1
- aeqb  out  1  AND of all f bits (74181 A=B convention)

## Operation
- Arithmetic (m=0): F = X + Y + cin, computed over WIDTH+1 bits; cout = bit WIDTH. ONES = all ones at WIDTH. X, Y by s:
  - 0000 A, 0
  - 0001 A|B, 0
  - 0010 A|~B, 0
  - 0011 ONES, 0
  - 0100 A, A&~B
  - 0101 A|B, A&~B
  - 0110 A, ~B
  - 0111 A&~B, ONES
  - 1000 A, A&B
  - 1001 A, B
  - 1010 A|~B, A&B
  - 1011 A&B, ONES
  - 1100 A, A
  - 1101 A|B, A
  - 1110 A|~B, A
  - 1111 A, ONES
- Logic (m=1), bitwise, by s:
  - 0000 ~A; 0001 ~(A|B); 0010 ~A&B; 0011 0
  - 0100 ~(A&B); 0101 ~B; 0110 A^B; 0111 A&~B
  - 1000 ~A|B; 1001 ~(A^B); 1010 B; 1011 A&B
  - 1100 ONES; 1101 A|~B; 1110 A|B; 1111 A
- FSM states:
  - IDLE: in_ready=1. On in_valid: capture a, b, s, m, cin; clear the nibble counter; load the carry register with cin; go to RUN.
  - RUN: each cycle the slice processes nibble[cnt] of the captured operands and the carry register. It writes f[4*cnt+3:4*cnt] and updates the carry register. On the last nibble it also records carry-into-MSB. After cnt = NIBBLES-1, go to DONE.
  - DONE: out_valid=1. When out_ready is high, go to IDLE.
- f, cout, ovf and aeqb are registered. They hold their values from entry to DONE until the next accept.
- in_valid in RUN or DONE is ignored. The request is not queued.

## Timing
- Reset (asynchronous, any state, including mid-RUN): state=IDLE, in_ready=1, out_valid=0, f=0, cout=0, ovf=0, aeqb=0, counter=0, carry=0. The partial result is discarded.
- Accept at edge k (in_valid and in_ready both high) → RUN for edges k+1..k+NIBBLES → out_valid high after edge k+NIBBLES.
- Output handshake completes on the edge where out_valid and out_ready are both high. in_ready rises the following cycle.
- Minimum issue interval: NIBBLES+2 cycles.
- out_ready held low: DONE persists indefinitely. All outputs stay stable and in_ready stays 0.
- WIDTH=4: a single RUN cycle.

## Structure
- Shared package alu_181_pkg:
  - state enum (IDLE, RUN, DONE)
  - named localparams for the 16 select codes and the two modes
- Sub-module alu_181_slice: combinational 4-bit slice.
  - Inputs: a, b, s, m, cin.
  - Outputs: f[3:0], cout, c3 (carry into bit 3).
  - X/Y are formed per slice. ONES per slice is 4'hF, so ONES is correct across slices.
- Top level: FSM, operand and result registers, counter of width $clog2(NIBBLES) (minimum 1), carry register.

## Test plan
- WIDTH=8, a=0x3C, b=0x15, s=1001, m=0, cin=0 → f=0x51, cout=0, ovf=0. out_valid 2 cycles after accept.
- a=0x3C, b=0x15, s=0110, cin=1 → f=0x27, cout=1 (no borrow). Then a=b=0x5A, s=0110, cin=0 → f=0xFF, aeqb=1, cout=0.
- a=0x7F, b=0x01, s=1001, cin=0 → f=0x80, ovf=1, cout=0. Then s=1111, a=0x00, cin=0 → f=0xFF, cout=0.
- m=1, s=0110, a=0xF0, b=0x3C, cin=1 → f=0xCC, cout=0, ovf=0. Sweep all 32 (s, m) codes with random operands at WIDTH=4, 8 and 32 against a reference model.
- out_ready low for 5 cycles in DONE, with in_valid pulsed meanwhile → outputs stable, in_ready=0, no new capture. The next operation is accepted only after the handshake.
- Assert rst_n during the second RUN cycle (WIDTH=16) → all outputs reset immediately. A fresh op after release completes in 4 RUN cycles with the correct result.
